// File: rtl/mmio_pkg.sv
// Shared MMIO constants and types.
// Holds the register-field and data widths that every slot core uses, the
// bridge FSM state type, and the slot numbers of cores on the bus.
package mmio_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int DATA_W      = 32;
  localparam int SLOT_ADDR_W = 3;

  // Slot assignments on the default eight-slot bus.
  localparam int SLOT_TIMER  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mmio_bridge_if.sv
// Processor-side request/acknowledge bus.
// master: processor (drives req/we/addr/wdata, receives rdata/ack/err)
// slave : bridge    (receives the request, returns rdata/ack/err)
// bus_addr is the word address {slot, reg}.
interface mmio_bridge_if #(
  parameter int SLOT_ADDR_W = 3
);
  import mmio_pkg::*;

  logic                          bus_req;
  logic                          bus_we;
  logic [SLOT_ADDR_W+REG_ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0]             bus_wdata;
  logic [DATA_W-1:0]             bus_rdata;
  logic                          bus_ack;
  logic                          bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack, bus_err
  );

endinterface

// File: rtl/mmio_slot_decoder.sv
// Slot index to one-hot chip select.
// i_slot         : slot field of the bus address
// o_cs           : one-hot select, all zero when the slot does not exist
// o_out_of_range : slot index >= NUM_SLOTS
module mmio_slot_decoder #(
  parameter int NUM_SLOTS   = 8,
  parameter int SLOT_ADDR_W = 3
) (
  input  logic [SLOT_ADDR_W-1:0] i_slot,
  output logic [NUM_SLOTS-1:0]   o_cs,
  output logic                   o_out_of_range
);

  always_comb begin
    o_cs           = '0;
    o_out_of_range = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (i_slot == SLOT_ADDR_W'(i)) begin
        o_cs[i]        = 1'b1;
        o_out_of_range = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// Processor bus to slot-core bridge.
// Turns one accepted bus request into exactly one single-cycle slot strobe
// and exactly one bus acknowledge; requests to nonexistent slots are
// acknowledged with bus_err and never strobe a slot.
// i_clk, i_reset (sync, active low)
// bus           : processor request/ack bus (slave side)
// o_slot_cs     : one-hot chip select, valid only with a strobe
// o_slot_read   : read strobe
// o_slot_write  : write strobe
// o_slot_addr   : register address, held between transactions
// o_slot_wdata  : write data, held between transactions
// i_slot_rdata  : flattened per-slot read data, slot i at [i*DATA_W +: DATA_W]
//
// state  | meaning
// IDLE   | waiting for bus_req; latches the request on acceptance
// ACCESS | one cycle: chip select + strobe to the slot, read data captured
// RESP   | one cycle: bus_ack (with bus_err if the slot was out of range)
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int NUM_SLOTS   = 8,
  parameter int SLOT_ADDR_W = 3
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  mmio_bridge_if.slave                bus,
  output logic [NUM_SLOTS-1:0]        o_slot_cs,
  output logic                        o_slot_read,
  output logic                        o_slot_write,
  output logic [REG_ADDR_W-1:0]       o_slot_addr,
  output logic [DATA_W-1:0]           o_slot_wdata,
  input  logic [NUM_SLOTS*DATA_W-1:0] i_slot_rdata
);

  state_e                r_state, w_state_nxt;
  logic                  r_we, w_we_nxt;
  logic [NUM_SLOTS-1:0]  r_cs, w_cs_nxt;
  logic                  r_rd, w_rd_nxt;
  logic                  r_wr, w_wr_nxt;
  logic [REG_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0]     r_wdata, w_wdata_nxt;
  logic                  r_ack, w_ack_nxt;
  logic                  r_err, w_err_nxt;
  logic [DATA_W-1:0]     r_rdata, w_rdata_nxt;

  logic [NUM_SLOTS-1:0]  w_dec_cs;
  logic                  w_dec_oor;
  logic [DATA_W-1:0]     w_rd_sel;

  mmio_slot_decoder #(
    .NUM_SLOTS  (NUM_SLOTS),
    .SLOT_ADDR_W(SLOT_ADDR_W)
  ) u_dec (
    .i_slot        (bus.bus_addr[SLOT_ADDR_W+REG_ADDR_W-1 -: SLOT_ADDR_W]),
    .o_cs          (w_dec_cs),
    .o_out_of_range(w_dec_oor)
  );

  // r_cs is one-hot during ACCESS, so it doubles as the read-mux select.
  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_cs[i]) w_rd_sel = i_slot_rdata[i*DATA_W +: DATA_W];
    end
  end

  // Outputs are computed for the next state and registered, so the strobe
  // appears exactly in the ACCESS cycle and the ack exactly in RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_cs_nxt    = '0;
    w_rd_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.bus_req) begin
          w_we_nxt    = bus.bus_we;
          w_addr_nxt  = bus.bus_addr[REG_ADDR_W-1:0];
          w_wdata_nxt = bus.bus_wdata;
          if (w_dec_oor) begin
            w_state_nxt = RESP;
            w_ack_nxt   = 1'b1;
            w_err_nxt   = 1'b1;
            w_rdata_nxt = '0;
          end else begin
            w_state_nxt = ACCESS;
            w_cs_nxt    = w_dec_cs;
            w_rd_nxt    = ~bus.bus_we;
            w_wr_nxt    = bus.bus_we;
          end
        end
      end
      ACCESS: begin
        w_state_nxt = RESP;
        w_ack_nxt   = 1'b1;
        w_rdata_nxt = r_we ? '0 : w_rd_sel;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_cs    <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_cs    <= w_cs_nxt;
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  assign o_slot_cs     = r_cs;
  assign o_slot_read   = r_rd;
  assign o_slot_write  = r_wr;
  assign o_slot_addr   = r_addr;
  assign o_slot_wdata  = r_wdata;
  assign bus.bus_ack   = r_ack;
  assign bus.bus_err   = r_err;
  assign bus.bus_rdata = r_rdata;

endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: dut_a has 8 slots (slot 7 valid), dut_b has 6 slots
// (slots 6 and 7 out of range). Both share clock and reset.
module tb_mmio_bridge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cs;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } strb_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } ack_t;

  typedef struct {
    int          dut;
    logic        we;
    logic [2:0]  slot;
    logic [4:0]  ra;
    logic [31:0] wd;
    logic [7:0]  exp_cs;
    logic        exp_err;
    logic [31:0] exp_rdata;
    string       tag;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  strb_t q_strb[$];
  ack_t  q_ack[$];

  logic        d_req   [2];
  logic        d_we    [2];
  logic [7:0]  d_addr  [2];
  logic [31:0] d_wdata [2];
  int          cur = 0;

  mmio_bridge_if #(.SLOT_ADDR_W(3)) bus_a ();
  mmio_bridge_if #(.SLOT_ADDR_W(3)) bus_b ();

  assign bus_a.bus_req   = d_req[0];
  assign bus_a.bus_we    = d_we[0];
  assign bus_a.bus_addr  = d_addr[0];
  assign bus_a.bus_wdata = d_wdata[0];
  assign bus_b.bus_req   = d_req[1];
  assign bus_b.bus_we    = d_we[1];
  assign bus_b.bus_addr  = d_addr[1];
  assign bus_b.bus_wdata = d_wdata[1];

  logic [7:0]     cs_a;
  logic           rds_a, wrs_a;
  logic [4:0]     saddr_a;
  logic [31:0]    swdata_a;
  logic [8*32-1:0] srdata_a;
  logic [5:0]     cs_b;
  logic           rds_b, wrs_b;
  logic [4:0]     saddr_b;
  logic [31:0]    swdata_b;
  logic [6*32-1:0] srdata_b;

  mmio_bridge #(.NUM_SLOTS(8), .SLOT_ADDR_W(3)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .bus(bus_a),
    .o_slot_cs(cs_a), .o_slot_read(rds_a), .o_slot_write(wrs_a),
    .o_slot_addr(saddr_a), .o_slot_wdata(swdata_a), .i_slot_rdata(srdata_a)
  );

  mmio_bridge #(.NUM_SLOTS(6), .SLOT_ADDR_W(3)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .bus(bus_b),
    .o_slot_cs(cs_b), .o_slot_read(rds_b), .o_slot_write(wrs_b),
    .o_slot_addr(saddr_b), .o_slot_wdata(swdata_b), .i_slot_rdata(srdata_b)
  );

  // Slot stubs: combinational from slot_addr; slot 5 reg 1 reads DEADBEEF.
  function automatic logic [31:0] stub(input int s, input logic [4:0] a);
    if (s == 5 && a == 5'd1) return 32'hDEAD_BEEF;
    return 32'hC000_0000 | (32'(s) << 16) | 32'(a);
  endfunction

  always_comb for (int i = 0; i < 8; i++) srdata_a[i*32 +: 32] = stub(i, saddr_a);
  always_comb for (int i = 0; i < 6; i++) srdata_b[i*32 +: 32] = stub(i, saddr_b);

  // Active-DUT view (m_*) and the other DUT's activity (o_*).
  logic [7:0]  m_cs, o_cs;
  logic        m_rd, m_wr, m_ack, m_err, o_rd, o_wr, o_ack;
  logic [4:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  always_comb begin
    if (cur == 0) begin
      m_cs = cs_a; m_rd = rds_a; m_wr = wrs_a; m_addr = saddr_a; m_wdata = swdata_a;
      m_ack = bus_a.bus_ack; m_err = bus_a.bus_err; m_rdata = bus_a.bus_rdata;
      o_cs = {2'b00, cs_b}; o_rd = rds_b; o_wr = wrs_b; o_ack = bus_b.bus_ack;
    end else begin
      m_cs = {2'b00, cs_b}; m_rd = rds_b; m_wr = wrs_b; m_addr = saddr_b; m_wdata = swdata_b;
      m_ack = bus_b.bus_ack; m_err = bus_b.bus_err; m_rdata = bus_b.bus_rdata;
      o_cs = cs_a; o_rd = rds_a; o_wr = wrs_a; o_ack = bus_a.bus_ack;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_strb = 0, n_ack_ok = 0, last_strb = 0, prev_strb = 0;
  strb_t mon_s;
  ack_t  mon_a;

  always @(negedge clk) begin
    chk("idle_dut_quiet", {21'd0, o_ack, o_rd, o_wr, o_cs}, 32'd0);
    if (m_rd || m_wr) begin
      chk("strobe_exclusive", 32'(m_rd && m_wr), 32'd0);
      if (q_strb.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        mon_s = q_strb.pop_front();
        chk("strobe_cs", 32'(m_cs), 32'(mon_s.cs));
        chk("strobe_write", 32'(m_wr), 32'(mon_s.we));
        chk("strobe_read", 32'(m_rd), 32'(!mon_s.we));
        chk("strobe_addr", 32'(m_addr), 32'(mon_s.addr));
        chk("strobe_wdata", m_wdata, mon_s.wdata);
      end
      n_strb++;
      prev_strb = last_strb;
      last_strb = cyc;
    end else begin
      chk("cs_without_strobe", 32'(m_cs), 32'd0);
    end
    if (m_ack) begin
      if (q_ack.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_a = q_ack.pop_front();
        chk("ack_err", 32'(m_err), 32'(mon_a.err));
        chk("ack_rdata", m_rdata, mon_a.rdata);
      end
      if (!m_err) n_ack_ok++;
    end
  end

  task automatic do_txn(input int dut, input bit pre_wait, input logic we,
                        input logic [2:0] slot, input logic [4:0] ra,
                        input logic [31:0] wd, input logic [7:0] ecs,
                        input logic eerr, input logic [31:0] erd, input string tag);
    int lat;
    bit got;
    if (pre_wait) @(negedge clk);
    cur          = dut;
    d_req[dut]   = 1'b1;
    d_we[dut]    = we;
    d_addr[dut]  = {slot, ra};
    d_wdata[dut] = wd;
    if (!eerr) q_strb.push_back('{cs: ecs, we: we, addr: ra, wdata: wd});
    q_ack.push_back('{err: eerr, rdata: erd});
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (m_ack) got = 1'b1;
    end
    d_req[dut] = 1'b0;
    chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), eerr ? 32'd1 : 32'd2);
    @(negedge clk);
    chk({tag, "_rdata_hold"}, m_rdata, erd);
    chk({tag, "_addr_hold"}, 32'(m_addr), 32'(ra));
    chk({tag, "_ack_single"}, 32'(m_ack), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cs"}, 32'(m_cs), 32'd0);
    chk({tag, "_strobes"}, 32'({m_rd, m_wr}), 32'd0);
    chk({tag, "_addr"}, 32'(m_addr), 32'd0);
    chk({tag, "_wdata"}, m_wdata, 32'd0);
    chk({tag, "_ack_err"}, 32'({m_ack, m_err}), 32'd0);
    chk({tag, "_rdata"}, m_rdata, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int    s0, a0;
    bit    got;
    for (int i = 0; i < 2; i++) begin
      d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
    end

    // Reset held three cycles with a request pending: nothing must happen.
    rst_n      = 1'b0;
    cur        = 0;
    d_req[0]   = 1'b1;
    d_we[0]    = 1'b1;
    d_addr[0]  = {3'd0, 5'd3};
    d_wdata[0] = 32'h0000_0005;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all_zero("reset");
    end
    rst_n = 1'b1;
    do_txn(0, 1'b0, 1'b1, 3'd0, 5'd3, 32'h0000_0005, 8'h01, 1'b0, 32'd0, "rst_release");

    vecs.push_back('{0, 1'b1, 3'd2, 5'd2,  32'h0000_0003, 8'b0000_0100, 1'b0, 32'h0000_0000, "wr_s2"});
    vecs.push_back('{0, 1'b0, 3'd5, 5'd1,  32'h0000_0000, 8'b0010_0000, 1'b0, 32'hDEAD_BEEF, "rd_s5"});
    vecs.push_back('{0, 1'b0, 3'd0, 5'd0,  32'h0000_0000, 8'b0000_0001, 1'b0, 32'hC000_0000, "rd_s0"});
    vecs.push_back('{0, 1'b0, 3'd7, 5'd31, 32'h0000_0000, 8'b1000_0000, 1'b0, 32'hC007_001F, "rd_s7"});
    vecs.push_back('{0, 1'b1, 3'd7, 5'd4,  32'hA5A5_5A5A, 8'b1000_0000, 1'b0, 32'h0000_0000, "wr_s7"});
    vecs.push_back('{0, 1'b0, 3'd3, 5'd1,  32'h0000_0000, 8'b0000_1000, 1'b0, 32'hC003_0001, "rd_s3"});
    vecs.push_back('{1, 1'b0, 3'd7, 5'd1,  32'h0000_0000, 8'b0000_0000, 1'b1, 32'h0000_0000, "oor_rd_s7"});
    vecs.push_back('{1, 1'b0, 3'd5, 5'd3,  32'h0000_0000, 8'b0010_0000, 1'b0, 32'hC005_0003, "b_rd_s5"});
    vecs.push_back('{1, 1'b1, 3'd6, 5'd0,  32'h0000_1234, 8'b0000_0000, 1'b1, 32'h0000_0000, "oor_wr_s6"});
    vecs.push_back('{1, 1'b0, 3'd0, 5'd9,  32'h0000_0000, 8'b0000_0001, 1'b0, 32'hC000_0009, "b_rd_s0"});
    vecs.push_back('{1, 1'b0, 3'd5, 5'd1,  32'h0000_0000, 8'b0010_0000, 1'b0, 32'hDEAD_BEEF, "b_rd_beef"});

    foreach (vecs[i])
      do_txn(vecs[i].dut, 1'b1, vecs[i].we, vecs[i].slot, vecs[i].ra, vecs[i].wd,
             vecs[i].exp_cs, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].tag);

    // Back-to-back: request held through the ack, retargeted from slot 0 to slot 7.
    @(negedge clk);
    cur = 0;
    s0  = n_strb;
    a0  = n_ack_ok;
    q_strb.push_back('{cs: 8'h01, we: 1'b1, addr: 5'd5, wdata: 32'h0000_1111});
    q_ack.push_back('{err: 1'b0, rdata: 32'd0});
    q_strb.push_back('{cs: 8'h80, we: 1'b1, addr: 5'd6, wdata: 32'h0000_2222});
    q_ack.push_back('{err: 1'b0, rdata: 32'd0});
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = {3'd0, 5'd5}; d_wdata[0] = 32'h0000_1111;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (m_ack) got = 1'b1;
    end
    chk("b2b_first_ack", 32'(got), 32'd1);
    d_addr[0] = {3'd7, 5'd6}; d_wdata[0] = 32'h0000_2222;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (m_ack) got = 1'b1;
    end
    d_req[0] = 1'b0;
    chk("b2b_second_ack", 32'(got), 32'd1);
    @(negedge clk);
    chk("b2b_spacing", 32'(last_strb - prev_strb), 32'd3);
    chk("b2b_strobes", 32'(n_strb - s0), 32'd2);
    chk("b2b_acks", 32'(n_ack_ok - a0), 32'd2);

    // Reset during the ACCESS cycle of a read abandons it without an ack.
    @(negedge clk);
    cur = 0;
    q_strb.push_back('{cs: 8'h20, we: 1'b0, addr: 5'd1, wdata: 32'd0});
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = {3'd5, 5'd1}; d_wdata[0] = 32'd0;
    @(negedge clk);
    chk("rstmid_in_access", 32'(m_rd), 32'd1);
    rst_n    = 1'b0;
    d_req[0] = 1'b0;
    @(negedge clk);
    chk_all_zero("rstmid");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid_no_ack", 32'(m_ack), 32'd0);
    end
    do_txn(0, 1'b1, 1'b0, 3'd5, 5'd1, 32'd0, 8'h20, 1'b0, 32'hDEAD_BEEF, "after_rst");

    chk("strobe_queue_empty", 32'(q_strb.size()), 32'd0);
    chk("ack_queue_empty", 32'(q_ack.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
